fifo_reader: RTL and testbench

//   Read-side controller for the synchronous FIFO. Drains words from the FIFO read port when enabled.

---
 rtl/fifo_reader.sv | 154 +++++++++++++++
 tb/tb_fifo_reader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_reader.sv
// fifo_reader: read-side controller for a synchronous FIFO.
// Drains FIFO words when enabled, packs PACK consecutive words LSB-first into
// one wide beat, and presents beats on a registered valid/ready stream.
// A flush pulse emits any partial beat, zero-padded, with m_cnt giving the
// number of valid words.
// Optional feature: define FIFO_READER_STATS_EN to add the rd_count and
// stall_count saturating statistics counters and their output ports.
module fifo_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4
`ifdef FIFO_READER_STATS_EN
  ,
  parameter int CNT_WIDTH  = 16
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          flush,
  input  logic                          fifo_empty,
  input  logic [DATA_WIDTH-1:0]         fifo_data,
  output logic                          fifo_rd_en,
  output logic [DATA_WIDTH*PACK-1:0]    m_data,
  output logic [$clog2(PACK+1)-1:0]     m_cnt,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          busy
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]          rd_count,
  output logic [CNT_WIDTH-1:0]          stall_count
`endif
);

  localparam int CW = $clog2(PACK + 1);
  localparam int BW = DATA_WIDTH * PACK;
  localparam logic [CW-1:0] PACK_C = CW'(PACK);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic           pend;        // a read was issued last cycle; fifo_data is valid now
  logic [BW-1:0]  acc_data;    // partial beat, unused slots kept at zero
  logic [CW-1:0]  acc_cnt;     // words held in acc_data (0..PACK)

  logic [BW-1:0]  acc_ins;     // accumulator including this cycle's returning word
  logic [CW-1:0]  cnt_ins;
  logic           out_free;
  logic           flush_emit;
  logic           load;
  logic [CW-1:0]  occ_next;

  // Datapath decisions: merge the landing word, decide whether a beat moves
  // to the output register, and issue a read only when its word has a slot.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; a missing default infers a latch.
    acc_ins = acc_data;
    for (int k = 0; k < PACK; k++) begin
      if (pend && (acc_cnt == CW'(k))) begin
        acc_ins[k*DATA_WIDTH +: DATA_WIDTH] = fifo_data;
      end
    end
    cnt_ins    = acc_cnt + CW'(pend);
    out_free   = !m_valid || m_ready;
    flush_emit = (state == FLUSH) && !pend && (acc_cnt != '0);
    load       = ((cnt_ins == PACK_C) || flush_emit) && out_free;
    // Words the accumulator will hold after this edge; a read issued now lands
    // next cycle and must find a free slot there.
    occ_next   = load ? '0 : cnt_ins;
    fifo_rd_en = (state == FILL) && en && !fifo_empty && !flush &&
                 (occ_next < PACK_C);
  end

  // Next-state logic; a flush pulse outside FLUSH takes priority.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (en && !fifo_empty) state_nxt = FILL;
      end
      FILL: begin
        if ((!en || fifo_empty) && !pend) state_nxt = IDLE;
      end
      FLUSH: begin
        // Leave once the in-flight word has landed and any partial beat has
        // been handed to the output register.
        if (!pend && ((acc_cnt == '0) || out_free)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush && (state != FLUSH)) state_nxt = FLUSH;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // In-flight read tracking; a read pending at reset is simply forgotten.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pend <= 1'b0;
    else      pend <= fifo_rd_en;
  end

  // Accumulator and registered output beat.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the accumulator is a plain register (not a RAM), so it is reset;
    // this keeps zero-padding of partial beats valid right after reset.
    if (!rst) begin
      acc_data <= '0;
      acc_cnt  <= '0;
      m_data   <= '0;
      m_cnt    <= '0;
      m_valid  <= 1'b0;
    end else if (load) begin
      m_data   <= acc_ins;
      m_cnt    <= cnt_ins;
      m_valid  <= 1'b1;
      acc_data <= '0;
      acc_cnt  <= '0;
    end else begin
      acc_data <= acc_ins;
      acc_cnt  <= cnt_ins;
      if (m_ready) m_valid <= 1'b0;
    end
  end

  assign busy = pend || (acc_cnt != '0) || m_valid;

`ifdef FIFO_READER_STATS_EN
  // Saturating statistics: words captured and output stall cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_count    <= '0;
      stall_count <= '0;
    end else begin
      if (pend && (rd_count != '1))                    rd_count    <= rd_count + 1'b1;
      if (m_valid && !m_ready && (stall_count != '1))  stall_count <= stall_count + 1'b1;
    end
  end
`else
  // Statistics disabled: no counters and no statistics ports in this build.
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed self-checking bench for fifo_reader (DATA_WIDTH=8, PACK=4).
// A simple FIFO model with one-cycle read latency feeds the DUT; a monitor
// records read strobes and accepted beats for the directed steps to compare.
module tb_fifo_reader;

  localparam int DW   = 8;
  localparam int PACK = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            flush;
  logic            fifo_empty;
  logic [DW-1:0]   fifo_data = '0;
  logic            fifo_rd_en;
  logic [31:0]     m_data;
  logic [2:0]      m_cnt;
  logic            m_valid;
  logic            m_ready;
  logic            busy;
`ifdef FIFO_READER_STATS_EN
  logic [15:0]     rd_count;
  logic [15:0]     stall_count;
`endif

  fifo_reader #(.DATA_WIDTH(DW), .PACK(PACK)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .flush      (flush),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .m_data     (m_data),
    .m_cnt      (m_cnt),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .busy       (busy)
`ifdef FIFO_READER_STATS_EN
    ,
    .rd_count   (rd_count),
    .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  // FIFO model: registered read, data valid the cycle after the strobe.
  logic [DW-1:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Monitor, sampled on the falling edge away from DUT updates.
  int          cyc = 0;
  int          rd_q[$];
  logic [31:0] beat_d[$];
  logic [2:0]  beat_c[$];
  int          bad_rd = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fifo_rd_en) rd_q.push_back(cyc);
    if (fifo_rd_en && fifo_empty) bad_rd <= bad_rd + 1;
    if (m_valid && m_ready) begin
      beat_d.push_back(m_data);
      beat_c.push_back(m_cnt);
    end
  end

  int n_vec = 0;
  int n_mis = 0;
  int b0, b1, r0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    mem[wr_ptr] = d;
    wr_ptr++;
  endtask

  task automatic wait_beats(input string tag, input int target, input int budget);
    int k;
    k = 0;
    while ((beat_d.size() < target) && (k < budget)) begin
      tick();
      k++;
    end
    check({tag, "_timeout"}, 32'(beat_d.size() >= target), 32'd1);
  endtask

  task automatic expect_beat(input string tag, input int idx,
                             input logic [31:0] d, input logic [2:0] c);
    check({tag, "_data"}, (idx < beat_d.size()) ? beat_d[idx] : 32'hxxxxxxxx, d);
    check({tag, "_cnt"},  (idx < beat_c.size()) ? 32'(beat_c[idx]) : 32'hxxxxxxxx, 32'(c));
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; flush = 1'b0; m_ready = 1'b0;
    #2;
    check("rst_rd_en",   32'(fifo_rd_en), 32'd0);
    check("rst_m_valid", 32'(m_valid),    32'd0);
    check("rst_m_data",  m_data,          32'd0);
    check("rst_m_cnt",   32'(m_cnt),      32'd0);
    check("rst_busy",    32'(busy),       32'd0);
    tick(2);
    rst = 1'b1;
    tick();

    // Four words, full throughput: four back-to-back reads, one beat.
    b0 = beat_d.size(); r0 = rd_q.size();
    m_ready = 1'b1; en = 1'b1;
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    wait_beats("s2", b0 + 1, 50);
    tick(3);
    check("s2_rd_cnt", 32'(rd_q.size() - r0), 32'd4);
    check("s2_rd_consecutive",
          (rd_q.size() >= r0 + 4) ? 32'(rd_q[r0+3] - rd_q[r0]) : 32'hxxxxxxxx, 32'd3);
    expect_beat("s2_beat", b0, 32'h04030201, 3'd4);
    check("s2_idle_busy", 32'(busy), 32'd0);

    // Backpressure: eight words, output stalled for 20 cycles.
    rst = 1'b0; #2; rst = 1'b1; tick();
    b0 = beat_d.size(); r0 = rd_q.size();
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    begin
      int k;
      k = 0;
      while (!m_valid && (k < 50)) begin
        tick();
        k++;
      end
    end
    for (int i = 0; i < 20; i++) begin
      if (i % 5 == 0) begin
        check("s3_hold_valid", 32'(m_valid), 32'd1);
        check("s3_hold_data",  m_data,       32'h04030201);
      end
      tick();
    end
    check("s3_all_read",  32'(rd_q.size() - r0), 32'd8);
    check("s3_stall_rd",  32'(fifo_rd_en),        32'd0);
    m_ready = 1'b1;
    wait_beats("s3", b0 + 2, 30);
    expect_beat("s3_beat0", b0,     32'h04030201, 3'd4);
    expect_beat("s3_beat1", b0 + 1, 32'h08070605, 3'd4);
`ifdef FIFO_READER_STATS_EN
    check("s3_rd_count",    32'(rd_count),    32'd8);
    check("s3_stall_count", 32'(stall_count), 32'd20);
`endif
    tick(2);

    // Partial beat flushed zero-padded; a second flush with nothing held is silent.
    b0 = beat_d.size();
    push(8'h0A); push(8'h0B); push(8'h0C);
    tick(10);
    check("s4_partial_busy",  32'(busy),    32'd1);
    check("s4_partial_valid", 32'(m_valid), 32'd0);
    flush = 1'b1; tick(); flush = 1'b0;
    wait_beats("s4", b0 + 1, 10);
    expect_beat("s4_beat", b0, 32'h000C0B0A, 3'd3);
    tick(2);
    check("s4_after_busy", 32'(busy), 32'd0);
    b1 = beat_d.size();
    flush = 1'b1; tick(); flush = 1'b0;
    tick(5);
    check("s4_empty_flush", 32'(beat_d.size() - b1), 32'd0);

    // en dropped after two words; partial retained across the idle gap.
    b0 = beat_d.size();
    push(8'h11); push(8'h22);
    tick(8);
    en = 1'b0;
    tick(10);
    check("s5_no_beat", 32'(beat_d.size() - b0), 32'd0);
    check("s5_busy",    32'(busy),               32'd1);
    push(8'h33); push(8'h44);
    tick(3);
    check("s5_no_read", 32'(wr_ptr - rd_ptr), 32'd2);
    en = 1'b1;
    wait_beats("s5", b0 + 1, 20);
    expect_beat("s5_beat", b0, 32'h44332211, 3'd4);
    tick(3);

    // Reset with a partial beat held; no stale words after release.
    b0 = beat_d.size();
    push(8'h99); push(8'hAA);
    tick(8);
    check("s6_partial_busy", 32'(busy), 32'd1);
    rst = 1'b0; #2;
    check("s6_rst_busy", 32'(busy), 32'd0);
    tick(); rst = 1'b1; tick();
    push(8'h55); push(8'h66); push(8'h77); push(8'h88);
    wait_beats("s6", b0 + 1, 30);
    expect_beat("s6_beat", b0, 32'h88776655, 3'd4);
    check("s6_beat_count", 32'(beat_d.size() - b0), 32'd1);
    tick(3);

    // Asynchronous reset mid-run with a beat held and reads under way.
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'hC0 + 8'(i));
    tick(8);
    check("s1_pre_valid", 32'(m_valid), 32'd1);
    rst = 1'b0; #2;
    check("s1_rd_en",   32'(fifo_rd_en), 32'd0);
    check("s1_m_valid", 32'(m_valid),    32'd0);
    check("s1_m_data",  m_data,          32'd0);
    check("s1_m_cnt",   32'(m_cnt),      32'd0);
    check("s1_busy",    32'(busy),       32'd0);
    en = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(2);

    check("no_read_when_empty", 32'(bad_rd), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
